cc_mux_rr_arbiter: RTL

//  Upstream controller for the 2:1 data mux (CC_MUX_21).
//  - Arbitrates round-robin between two valid/ready producer channels.
//  - Drives the mux select line.
//  - Registers the mux output into a one-word output stage with a valid/ready handshake to the consumer.
//  - Keeps a saturating grant counter per channel for debug.

---
 rtl/cc_mux_rr_arbiter_pkg.sv | 33 +++
 rtl/cc_mux_rr_grant.sv | 35 +++
 rtl/cc_mux_rr_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cc_mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin controller of the 2:1 data mux:
// output-stage state encoding, channel codes and the tie-break helper.
package cc_mux_rr_arbiter_pkg;

    // Output stage occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Channel codes double as the mux select value.
    localparam logic GRANT_CH1 = 1'b0;
    localparam logic GRANT_CH2 = 1'b1;

    // Pick the channel to serve from the request pattern. A tie goes to the
    // channel that was not served last. With no request the previous
    // channel is returned so the mux select stays put.
    function automatic logic rr_pick(input logic valid1, input logic valid2,
                                     input logic last_grant);
        logic pick;
        if (valid1 && valid2) begin
            pick = (last_grant == GRANT_CH1) ? GRANT_CH2 : GRANT_CH1;
        end else if (valid1) begin
            pick = GRANT_CH1;
        end else if (valid2) begin
            pick = GRANT_CH2;
        end else begin
            pick = last_grant;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cc_mux_rr_grant.sv
// Combinational grant decision: which producer is served this cycle, the
// mux select it implies and the per-channel ready strobes.
module cc_mux_rr_grant
    import cc_mux_rr_arbiter_pkg::*;
(
    input  logic valid1_i,
    input  logic valid2_i,
    input  logic last_grant_i,
    input  logic accept_i,
    output logic grant_valid_o,
    output logic grant_ch_o,
    output logic select_o,
    output logic ready1_o,
    output logic ready2_o
);

    logic pick_s;

    // Decide the grant; select falls back to the last served channel when idle.
    always_comb begin
        pick_s        = rr_pick(valid1_i, valid2_i, last_grant_i);
        grant_valid_o = accept_i & (valid1_i | valid2_i);
        grant_ch_o    = pick_s;
        if (grant_valid_o) begin
            select_o = pick_s;
            ready1_o = (pick_s == GRANT_CH1);
            ready2_o = (pick_s == GRANT_CH2);
        end else begin
            select_o = last_grant_i;
            ready1_o = 1'b0;
            ready2_o = 1'b0;
        end
    end

endmodule

// File: rtl/cc_mux_rr_arbiter.sv
// Upstream controller for the external 2:1 data mux. Arbitrates two
// valid/ready producers round-robin, steers the mux, registers the mux
// output into a one-word stage towards the consumer and counts grants.
module cc_mux_rr_arbiter
    import cc_mux_rr_arbiter_pkg::*;
#(
    parameter int NUMBER_DATAWIDTH = 8,
    parameter int NUMBER_CNTWIDTH  = 8
) (
    input  logic                        CC_MUX_ARB_CLOCK_50,
    input  logic                        CC_MUX_ARB_RESET_InLow,
    input  logic                        CC_MUX_ARB_valid1_In,
    input  logic                        CC_MUX_ARB_valid2_In,
    output logic                        CC_MUX_ARB_ready1_Out,
    output logic                        CC_MUX_ARB_ready2_Out,
    output logic                        CC_MUX_ARB_select_Out,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_MUX_ARB_muxz_InBUS,
    output logic [NUMBER_DATAWIDTH-1:0] CC_MUX_ARB_data_OutBUS,
    output logic                        CC_MUX_ARB_valid_Out,
    input  logic                        CC_MUX_ARB_ready_In,
    output logic [NUMBER_CNTWIDTH-1:0]  CC_MUX_ARB_cnt1_OutBUS,
    output logic [NUMBER_CNTWIDTH-1:0]  CC_MUX_ARB_cnt2_OutBUS
);

    localparam logic [NUMBER_CNTWIDTH-1:0] CNT_ONE = {{(NUMBER_CNTWIDTH-1){1'b0}}, 1'b1};

    state_e                      state_q;
    logic [NUMBER_DATAWIDTH-1:0] data_q;
    logic                        last_grant_q;
    logic [NUMBER_CNTWIDTH-1:0]  cnt1_q;
    logic [NUMBER_CNTWIDTH-1:0]  cnt2_q;
    logic [NUMBER_CNTWIDTH-1:0]  cnt1_d;
    logic [NUMBER_CNTWIDTH-1:0]  cnt2_d;

    logic accept_s;
    logic grant_valid_s;
    logic grant_ch_s;

    // The stage can take a word when empty or when the held word leaves this
    // cycle; nothing is accepted while reset is asserted.
    always_comb begin
        if (!CC_MUX_ARB_RESET_InLow) begin
            accept_s = 1'b0;
        end else begin
            accept_s = (state_q == ST_EMPTY) | CC_MUX_ARB_ready_In;
        end
    end

    cc_mux_rr_grant u_grant (
        .valid1_i      (CC_MUX_ARB_valid1_In),
        .valid2_i      (CC_MUX_ARB_valid2_In),
        .last_grant_i  (last_grant_q),
        .accept_i      (accept_s),
        .grant_valid_o (grant_valid_s),
        .grant_ch_o    (grant_ch_s),
        .select_o      (CC_MUX_ARB_select_Out),
        .ready1_o      (CC_MUX_ARB_ready1_Out),
        .ready2_o      (CC_MUX_ARB_ready2_Out)
    );

    // Output stage FSM with its data register and round-robin pointer.
    always_ff @(posedge CC_MUX_ARB_CLOCK_50) begin
        if (!CC_MUX_ARB_RESET_InLow) begin
            state_q      <= ST_EMPTY;
            data_q       <= {NUMBER_DATAWIDTH{1'b0}};
            last_grant_q <= GRANT_CH2;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (grant_valid_s) begin
                        state_q <= ST_FULL;
                    end else begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (grant_valid_s) begin
                        state_q <= ST_FULL;
                    end else if (CC_MUX_ARB_ready_In) begin
                        state_q <= ST_EMPTY;
                    end else begin
                        state_q <= ST_FULL;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
            if (grant_valid_s) begin
                data_q       <= CC_MUX_ARB_muxz_InBUS;
                last_grant_q <= grant_ch_s;
            end else begin
                data_q       <= data_q;
                last_grant_q <= last_grant_q;
            end
        end
    end

    // Next value of the saturating grant counters.
    always_comb begin
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (grant_valid_s && (grant_ch_s == GRANT_CH1) && !(&cnt1_q)) begin
            cnt1_d = cnt1_q + CNT_ONE;
        end else begin
            cnt1_d = cnt1_q;
        end
        if (grant_valid_s && (grant_ch_s == GRANT_CH2) && !(&cnt2_q)) begin
            cnt2_d = cnt2_q + CNT_ONE;
        end else begin
            cnt2_d = cnt2_q;
        end
    end

    // Grant counter registers.
    always_ff @(posedge CC_MUX_ARB_CLOCK_50) begin
        if (!CC_MUX_ARB_RESET_InLow) begin
            cnt1_q <= {NUMBER_CNTWIDTH{1'b0}};
            cnt2_q <= {NUMBER_CNTWIDTH{1'b0}};
        end else begin
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    assign CC_MUX_ARB_valid_Out   = (state_q == ST_FULL);
    assign CC_MUX_ARB_data_OutBUS = data_q;
    assign CC_MUX_ARB_cnt1_OutBUS = cnt1_q;
    assign CC_MUX_ARB_cnt2_OutBUS = cnt2_q;

endmodule
